// File: rtl/pwc_pkg.sv
// Shared types and constants for the pixel write combiner.
package pwc_pkg;

    localparam int unsigned BURST_PIXELS  = 8;
    localparam int unsigned BEAT_PIXELS   = BURST_PIXELS / 2;
    localparam int unsigned TAG_W         = 27;
    localparam int unsigned SLOT_W        = 3;
    localparam int unsigned PX_W          = 32;
    localparam int unsigned BYTES_PER_PX  = PX_W / 8;
    localparam int unsigned AF_ADDR_W     = 31;
    localparam int unsigned WDF_W         = 128;
    localparam int unsigned MASK_W        = 16;

    typedef enum logic [2:0] {
        EMPTY,
        FILL,
        DRAIN_AF,
        DRAIN_W0,
        DRAIN_W1
    } pwc_state_e;

endpackage

// File: rtl/pwc_burst_buffer.sv
// One 32-byte burst: 8 pixel slots, valid vector and tag.
// Presents both 128-bit write-data beats and their byte masks combinationally.
module pwc_burst_buffer
    import pwc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic                    load_tag,
    input  logic [SLOT_W-1:0]       wr_slot,
    input  logic [PX_W-1:0]         wr_data,
    input  logic [TAG_W-1:0]        wr_tag,
    output logic [TAG_W-1:0]        tag,
    output logic [BURST_PIXELS-1:0] valid,
    output logic [WDF_W-1:0]        beat0_data,
    output logic [WDF_W-1:0]        beat1_data,
    output logic [MASK_W-1:0]       beat0_mask,
    output logic [MASK_W-1:0]       beat1_mask
);

    logic [PX_W-1:0]         slot_q [BURST_PIXELS];
    logic [BURST_PIXELS-1:0] valid_q;
    logic [BURST_PIXELS-1:0] valid_d;
    logic [TAG_W-1:0]        tag_q;

    // Clear and write may coincide: the written slot becomes the only valid one.
    always_comb begin
        valid_d = clear ? '0 : valid_q;
        if (wr_en) valid_d[wr_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int unsigned i = 0; i < BURST_PIXELS; i++) slot_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_tag) tag_q <= wr_tag;
            if (wr_en) slot_q[wr_slot] <= wr_data;
        end
    end

    always_comb begin
        beat0_data = '0;
        beat1_data = '0;
        beat0_mask = '1;
        beat1_mask = '1;
        for (int unsigned i = 0; i < BEAT_PIXELS; i++) begin
            beat0_data[PX_W*i +: PX_W]                 = slot_q[i];
            beat1_data[PX_W*i +: PX_W]                 = slot_q[i+BEAT_PIXELS];
            beat0_mask[BYTES_PER_PX*i +: BYTES_PER_PX] = {BYTES_PER_PX{~valid_q[i]}};
            beat1_mask[BYTES_PER_PX*i +: BYTES_PER_PX] = {BYTES_PER_PX{~valid_q[i+BEAT_PIXELS]}};
        end
    end

    assign tag   = tag_q;
    assign valid = valid_q;

endmodule

// File: rtl/pixel_write_combiner.sv
// Merges single-pixel writes into 32-byte bursts for the DDR2 address/write-data FIFOs.
// Optional idle auto-flush enabled by defining PWC_TIMEOUT_EN.
module pixel_write_combiner
    import pwc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 px_valid,
    output logic                 px_ready,
    input  logic [31:0]          px_addr,
    input  logic [PX_W-1:0]      px_data,
    input  logic                 flush,
    output logic                 idle,
    input  logic                 af_full,
    output logic [AF_ADDR_W-1:0] af_addr_din,
    output logic                 af_wr_en,
    input  logic                 wdf_full,
    output logic [WDF_W-1:0]     wdf_din,
    output logic [MASK_W-1:0]    wdf_mask_din,
    output logic                 wdf_wr_en
);

    pwc_state_e state_q, state_d;

    logic px_ready_q, idle_q;
    logic accept, hit, full_after, timeout_fire;

    logic [TAG_W-1:0]  px_tag;
    logic [SLOT_W-1:0] px_slot;

    logic              pend_valid_q, pend_valid_d;
    logic [TAG_W-1:0]  pend_tag_q;
    logic [SLOT_W-1:0] pend_slot_q;
    logic [PX_W-1:0]   pend_data_q;
    logic              pend_load, pend_clear;

    logic                    buf_wr_en, buf_load_tag, buf_clear, wr_from_pend;
    logic [SLOT_W-1:0]       buf_wr_slot;
    logic [PX_W-1:0]         buf_wr_data;
    logic [TAG_W-1:0]        buf_wr_tag;
    logic [TAG_W-1:0]        buf_tag;
    logic [BURST_PIXELS-1:0] buf_valid;
    logic [WDF_W-1:0]        beat0_data, beat1_data;
    logic [MASK_W-1:0]       beat0_mask, beat1_mask;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^px_addr[1:0];

    assign px_tag     = px_addr[31:5];
    assign px_slot    = px_addr[4:2];
    assign accept     = px_valid && px_ready_q;
    assign hit        = (px_tag == buf_tag);
    assign full_after = &(buf_valid | (BURST_PIXELS'(1) << px_slot));

`ifdef PWC_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Fires on the TIMEOUT-th consecutive idle cycle in FILL.
    assign timeout_fire = (state_q == FILL) && !accept && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           to_cnt_q <= '0;
        else if (state_q != FILL || accept) to_cnt_q <= '0;
        else                                to_cnt_q <= to_cnt_q + TO_W'(1);
    end
`else
    localparam int unsigned timeout_unused = TIMEOUT;
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            px_ready_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            px_ready_q <= (state_d == EMPTY) || (state_d == FILL);
            idle_q     <= (state_d == EMPTY) && !pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_wr_en    = 1'b0;
        buf_load_tag = 1'b0;
        buf_clear    = 1'b0;
        wr_from_pend = 1'b0;
        pend_load    = 1'b0;
        pend_clear   = 1'b0;
        af_wr_en     = 1'b0;
        wdf_wr_en    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    buf_wr_en    = 1'b1;
                    buf_load_tag = 1'b1;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (accept && hit) begin
                    buf_wr_en = 1'b1;
                    if (full_after || flush) state_d = DRAIN_AF;
                end else if (accept) begin
                    pend_load = 1'b1;
                    state_d   = DRAIN_AF;
                end else if (flush || timeout_fire) begin
                    state_d = DRAIN_AF;
                end
            end
            DRAIN_AF: begin
                af_wr_en = !af_full;
                if (!af_full) state_d = DRAIN_W0;
            end
            DRAIN_W0: begin
                wdf_wr_en = !wdf_full;
                if (!wdf_full) state_d = DRAIN_W1;
            end
            DRAIN_W1: begin
                wdf_wr_en = !wdf_full;
                if (!wdf_full) begin
                    buf_clear = 1'b1;
                    if (pend_valid_q) begin
                        buf_wr_en    = 1'b1;
                        buf_load_tag = 1'b1;
                        wr_from_pend = 1'b1;
                        pend_clear   = 1'b1;
                        state_d      = FILL;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        if (pend_load)       pend_valid_d = 1'b1;
        else if (pend_clear) pend_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_tag_q   <= '0;
            pend_slot_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            if (pend_load) begin
                pend_tag_q  <= px_tag;
                pend_slot_q <= px_slot;
                pend_data_q <= px_data;
            end
        end
    end

    assign buf_wr_slot = wr_from_pend ? pend_slot_q : px_slot;
    assign buf_wr_data = wr_from_pend ? pend_data_q : px_data;
    assign buf_wr_tag  = wr_from_pend ? pend_tag_q  : px_tag;

    pwc_burst_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (buf_clear),
        .wr_en      (buf_wr_en),
        .load_tag   (buf_load_tag),
        .wr_slot    (buf_wr_slot),
        .wr_data    (buf_wr_data),
        .wr_tag     (buf_wr_tag),
        .tag        (buf_tag),
        .valid      (buf_valid),
        .beat0_data (beat0_data),
        .beat1_data (beat1_data),
        .beat0_mask (beat0_mask),
        .beat1_mask (beat1_mask)
    );

    // Address bit 31 takes part in the tag compare but is not part of the FIFO address.
    assign af_addr_din  = {buf_tag[TAG_W-2:0], 5'b00000};
    assign wdf_din      = (state_q == DRAIN_W1) ? beat1_data : beat0_data;
    assign wdf_mask_din = (state_q == DRAIN_W1) ? beat1_mask : beat0_mask;
    assign px_ready     = px_ready_q;
    assign idle         = idle_q;

endmodule

// File: tb/tb_pixel_write_combiner.sv
// Directed self-checking bench for pixel_write_combiner.
`timescale 1ns/1ps
module tb_pixel_write_combiner;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         px_valid = 1'b0;
    logic         flush = 1'b0;
    logic         af_full = 1'b0;
    logic         wdf_full = 1'b0;
    logic [31:0]  px_addr = '0;
    logic [31:0]  px_data = '0;
    logic         px_ready, idle, af_wr_en, wdf_wr_en;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    always #5 clk = ~clk;

    pixel_write_combiner #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .px_addr      (px_addr),
        .px_data      (px_data),
        .flush        (flush),
        .idle         (idle),
        .af_full      (af_full),
        .af_addr_din  (af_addr_din),
        .af_wr_en     (af_wr_en),
        .wdf_full     (wdf_full),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din),
        .wdf_wr_en    (wdf_wr_en)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned acc_edge = 0;
    logic        both_seen = 1'b0;

    logic [30:0]  af_addr_q[$];
    int unsigned  af_edge_q[$];
    logic [127:0] wd_q[$];
    logic [15:0]  wm_q[$];
    int unsigned  wd_edge_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1ns after posedge; at negedge they are stable and the
    // strobes show exactly what the next posedge will push.
    always @(negedge clk) begin
        if (px_valid && px_ready) acc_edge = cyc + 1;
        if (af_wr_en) begin
            af_addr_q.push_back(af_addr_din);
            af_edge_q.push_back(cyc + 1);
        end
        if (wdf_wr_en) begin
            wd_q.push_back(wdf_din);
            wm_q.push_back(wdf_mask_din);
            wd_edge_q.push_back(cyc + 1);
        end
        if (af_wr_en && wdf_wr_en) both_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] wd_at(input int unsigned i);
        return (i < wd_q.size()) ? wd_q[i] : 'x;
    endfunction

    function automatic logic [15:0] wm_at(input int unsigned i);
        return (i < wm_q.size()) ? wm_q[i] : 'x;
    endfunction

    function automatic logic [30:0] af_at(input int unsigned i);
        return (i < af_addr_q.size()) ? af_addr_q[i] : 'x;
    endfunction

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        af_addr_q.delete();
        af_edge_q.delete();
        wd_q.delete();
        wm_q.delete();
        wd_edge_q.delete();
    endtask

    task automatic send_px(input logic [31:0] a, input logic [31:0] d);
        int unsigned n = 0;
        step(1);
        while (!px_ready && n < 200) begin
            step(1);
            n++;
        end
        if (!px_ready) check_eq("px_ready_wait", {127'd0, px_ready}, 128'd1);
        px_valid = 1'b1;
        px_addr  = a;
        px_data  = d;
        step(1);
        px_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (!idle && n < 200) begin
            step(1);
            n++;
        end
        check_eq(tag, {127'd0, idle}, 128'd1);
    endtask

    task automatic wait_af(input string tag);
        int unsigned n = 0;
        while (af_addr_q.size() == 0 && n < 200) begin
            step(1);
            n++;
        end
        check_eq(tag, 128'(af_addr_q.size()), 128'd1);
    endtask

    int unsigned miss_edge;

    initial begin
        // Reset state
        step(3);
        check_eq("rst_idle",    {127'd0, idle},      128'd1);
        check_eq("rst_ready",   {127'd0, px_ready},  128'd0);
        check_eq("rst_af_wr",   {127'd0, af_wr_en},  128'd0);
        check_eq("rst_wdf_wr",  {127'd0, wdf_wr_en}, 128'd0);
        rst = 1'b1;
        step(1);
        check_eq("ready_after_rst", {127'd0, px_ready}, 128'd1);

        // Flush while empty does nothing
        clear_mon();
        pulse_flush();
        step(5);
        check_eq("empty_flush_af", 128'(af_addr_q.size()), 128'd0);
        check_eq("empty_flush_idle", {127'd0, idle}, 128'd1);

        // Full burst of 8 pixels
        clear_mon();
        for (int unsigned i = 0; i < 8; i++) send_px(32'h10400000 + 32'(4 * i), 32'h00A0B000 + 32'(i));
        step(1);
        check_eq("full_af_lat", 128'(af_edge_q.size() > 0 ? af_edge_q[0] - acc_edge : 99), 128'd1);
        wait_idle("full_idle");
        check_eq("full_af_cnt", 128'(af_addr_q.size()), 128'd1);
        check_eq("full_af_addr", {97'd0, af_at(0)}, 128'h10400000);
        check_eq("full_wd_cnt", 128'(wd_q.size()), 128'd2);
        check_eq("full_m0", {112'd0, wm_at(0)}, 128'h0000);
        check_eq("full_m1", {112'd0, wm_at(1)}, 128'h0000);
        check_eq("full_d0", wd_at(0), 128'h00A0B003_00A0B002_00A0B001_00A0B000);
        check_eq("full_d1", wd_at(1), 128'h00A0B007_00A0B006_00A0B005_00A0B004);
        check_eq("full_w_lat", 128'(wd_edge_q.size() == 2 ? (wd_edge_q[0] - acc_edge) * 10 + (wd_edge_q[1] - acc_edge) : 0), 128'd23);

        // Partial burst, flush
        clear_mon();
        send_px(32'h10400004, 32'h00112233);
        send_px(32'h10400008, 32'h00445566);
        pulse_flush();
        wait_idle("part_idle");
        check_eq("part_af_cnt", 128'(af_addr_q.size()), 128'd1);
        check_eq("part_af_addr", {97'd0, af_at(0)}, 128'h10400000);
        check_eq("part_wd_cnt", 128'(wd_q.size()), 128'd2);
        check_eq("part_m0", {112'd0, wm_at(0)}, 128'hF00F);
        check_eq("part_m1", {112'd0, wm_at(1)}, 128'hFFFF);
        check_eq("part_d0_s1", {96'd0, wd_at(0)[63:32]}, 128'h00112233);
        check_eq("part_d0_s2", {96'd0, wd_at(0)[95:64]}, 128'h00445566);

        // Miss goes to pending, first burst drains
        clear_mon();
        send_px(32'h10400000, 32'h00010203);
        send_px(32'h10400020, 32'h00040506);
        miss_edge = acc_edge;
        step(8);
        check_eq("miss_af_cnt", 128'(af_addr_q.size()), 128'd1);
        check_eq("miss_af_lat", 128'(af_edge_q.size() > 0 ? af_edge_q[0] - miss_edge : 99), 128'd1);
        check_eq("miss_af_addr", {97'd0, af_at(0)}, 128'h10400000);
        check_eq("miss_m0", {112'd0, wm_at(0)}, 128'hFFF0);
        check_eq("miss_m1", {112'd0, wm_at(1)}, 128'hFFFF);
        check_eq("miss_d0", {96'd0, wd_at(0)[31:0]}, 128'h00010203);
        check_eq("miss_idle", {127'd0, idle}, 128'd0);
        check_eq("miss_ready", {127'd0, px_ready}, 128'd1);
        clear_mon();
        pulse_flush();
        wait_idle("pend_idle");
        check_eq("pend_af_addr", {97'd0, af_at(0)}, 128'h10400020);
        check_eq("pend_wd_cnt", 128'(wd_q.size()), 128'd2);
        check_eq("pend_m0", {112'd0, wm_at(0)}, 128'hFFF0);
        check_eq("pend_d0", {96'd0, wd_at(0)[31:0]}, 128'h00040506);

        // FIFO full stalls
        clear_mon();
        af_full = 1'b1;
        send_px(32'h10400010, 32'h00778899);
        pulse_flush();
        step(10);
        check_eq("stall_af_cnt", 128'(af_addr_q.size()), 128'd0);
        check_eq("stall_wd_cnt", 128'(wd_q.size()), 128'd0);
        check_eq("stall_ready", {127'd0, px_ready}, 128'd0);
        af_full = 1'b0;
        wait_af("stall_af_push");
        wdf_full = 1'b1;
        step(3);
        check_eq("stall_wd_hold", 128'(wd_q.size()), 128'd0);
        wdf_full = 1'b0;
        wait_idle("stall_idle");
        check_eq("stall_af_total", 128'(af_addr_q.size()), 128'd1);
        check_eq("stall_wd_total", 128'(wd_q.size()), 128'd2);
        check_eq("stall_m0", {112'd0, wm_at(0)}, 128'hFFFF);
        check_eq("stall_m1", {112'd0, wm_at(1)}, 128'hFFF0);
        check_eq("stall_d1", {96'd0, wd_at(1)[31:0]}, 128'h00778899);

        // Reset discards an open burst
        clear_mon();
        send_px(32'h10400000, 32'h00000001);
        send_px(32'h10400004, 32'h00000002);
        send_px(32'h10400008, 32'h00000003);
        step(1);
        rst = 1'b0;
        #1;
        check_eq("mrst_idle",  {127'd0, idle},     128'd1);
        check_eq("mrst_ready", {127'd0, px_ready}, 128'd0);
        step(1);
        rst = 1'b1;
        step(2);
        check_eq("mrst_af_cnt", 128'(af_addr_q.size()), 128'd0);
        check_eq("mrst_wd_cnt", 128'(wd_q.size()), 128'd0);
        check_eq("mrst_idle_after", {127'd0, idle}, 128'd1);
        send_px(32'h10400014, 32'h00CAFE00);
        pulse_flush();
        wait_idle("mrst_fresh_idle");
        check_eq("mrst_fresh_af", 128'(af_addr_q.size()), 128'd1);
        check_eq("mrst_fresh_m0", {112'd0, wm_at(0)}, 128'hFFFF);
        check_eq("mrst_fresh_m1", {112'd0, wm_at(1)}, 128'hFF0F);

        // Idle burst: timeout drain, or stays open without the feature
        clear_mon();
`ifdef PWC_TIMEOUT_EN
        send_px(32'hA0000008, 32'h00123456);
        wait_af("to_af_push");
        check_eq("to_af_lat", 128'(af_edge_q.size() > 0 ? af_edge_q[0] - acc_edge : 99), 128'd5);
        check_eq("to_af_addr", {97'd0, af_at(0)}, 128'h20000000);
        wait_idle("to_idle");
`else
        send_px(32'hA0000008, 32'h00123456);
        step(30);
        check_eq("open_af_cnt", 128'(af_addr_q.size()), 128'd0);
        check_eq("open_idle", {127'd0, idle}, 128'd0);
        pulse_flush();
        wait_idle("open_flush_idle");
        check_eq("open_af_addr", {97'd0, af_at(0)}, 128'h20000000);
`endif
        check_eq("open_m0", {112'd0, wm_at(0)}, 128'hF0FF);

        check_eq("af_wdf_exclusive", {127'd0, both_seen}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_combiner.md
# pixel_write_combiner

Sits between the line engine / pixel writers and the DDR2 address and write-data FIFOs, replacing the per-pixel bypass path. It accepts single 32-bit pixel writes and merges those that fall in the same 32-byte burst (8 pixels) into one buffer entry. Each buffer is drained as one address-FIFO write plus two 128-bit write-data beats with byte masks, which cuts FIFO traffic for horizontal line runs by up to 8x.

## Interface
- `TIMEOUT`, default 64: idle cycles before an auto-flush. Only used when `PWC_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `px_valid`  in  1  pixel write request.
- `px_ready`  out  1  pixel accepted when `px_valid && px_ready` at a rising edge.
- `px_addr`  in  32  byte address of the pixel; bits [1:0] are ignored.
- `px_data`  in  32  pixel value `{8'h00, R, G, B}`.
- `flush`  in  1  one-cycle pulse: drain the open burst.
- `idle`  out  1  buffer empty, nothing pending, no drain in progress.
- `af_full`  in  1  address FIFO full.
- `af_addr_din`  out  31  `{px_addr[30:5], 5'b00000}` of the burst.
- `af_wr_en`  out  1  address FIFO push.
- `wdf_full`  in  1  write-data FIFO full.
- `wdf_din`  out  128  write-data beat.
- `wdf_mask_din`  out  16  byte mask; 1 = byte NOT written.
- `wdf_wr_en`  out  1  write-data FIFO push.

## Operation
- Storage:
  - 8 x 32-bit data slots plus an 8-bit valid vector.
  - 27-bit tag holding `px_addr[31:5]`.
  - One pending pixel register (address + data + valid flag).
- Slot index is `px_addr[4:2]`. A write to an already-valid slot overwrites it (last write wins).
- FSM states: `EMPTY`, `FILL`, `DRAIN_AF`, `DRAIN_W0`, `DRAIN_W1`.
- `EMPTY`: an accepted pixel loads the tag, sets one valid bit, and moves to `FILL`. `flush` in this state is a no-op.
- `FILL`:
  - Hit (tag match): merge the pixel. If all 8 valid bits are then set, go to `DRAIN_AF`.
  - Miss: the pixel is accepted into the pending register; go to `DRAIN_AF`.
  - `flush`: go to `DRAIN_AF`. If `flush` and a hit coincide, merge first, then drain. If `flush` and a miss coincide, the miss pixel goes to pending.
- `DRAIN_AF`: `af_wr_en = !af_full`; advance to `DRAIN_W0` on the push.
- `DRAIN_W0` pushes slots 0..3 and `DRAIN_W1` pushes slots 4..7:
  - Slot i goes to `wdf_din[32*(i%4) +: 32]`.
  - Mask bits `[4*(i%4) +: 4] = {4{~valid[i]}}`.
  - Each beat sets `wdf_wr_en = !wdf_full` and advances on the push.
- After `DRAIN_W1`: clear the valid bits. If pending is valid, load it as the first entry and go to `FILL`; otherwise go to `EMPTY`.
- `px_ready` is registered: 1 in `EMPTY` and `FILL`, 0 in all `DRAIN_*` states.
- A burst with all 8 slots valid drives mask `16'h0000` on both beats.
- A beat with no valid slots is still pushed, with mask `16'hFFFF`. The AF/WDF pairing is always 1:2.

## Timing
- Reset (`rst` low), asynchronous:
  - State `EMPTY`, valid bits and pending cleared.
  - `af_wr_en=0`, `wdf_wr_en=0`, `px_ready=0`, `idle=1`.
  - Any in-flight burst is discarded; no partial beat is emitted.
- First rising edge after `rst` deasserts: `px_ready=1`.
- The 8th merging pixel accepted at edge t gives `af_wr_en=1` in cycle t+1 (when `af_full=0`), then beats at t+2 and t+3.
- A miss pixel accepted at t: drain starts at t+1, and `px_ready` returns in the cycle after the `DRAIN_W1` push.
- FIFO full stalls hold the state and all outputs except the `wr_en` signals. Stalls never drop or reorder beats.
- `af_wr_en` and `wdf_wr_en` are combinational on state and full. They are never both high in the same cycle.
- `idle` is registered. It is 1 only in `EMPTY` with pending invalid.

## Configuration
- `PWC_TIMEOUT_EN` defined:
  - A counter (`$clog2(TIMEOUT+1)` bits) runs in `FILL`.
  - It resets on every accepted pixel.
  - Reaching `TIMEOUT` forces `DRAIN_AF`, exactly like `flush`.
- `PWC_TIMEOUT_EN` undefined: no counter. Drain happens only on full, miss, or `flush`; a partial burst can stay open indefinitely.

## Structure
- Package `pwc_pkg` holds:
  - the state enum;
  - `BURST_PIXELS=8`;
  - `TAG_W=27` and `SLOT_W=3`;
  - the `AF_ADDR_W=31`, `WDF_W=128` and `MASK_W=16` constants.
- Sub-module `pwc_burst_buffer` holds the 8 data slots, the valid vector and the tag, with write and clear ports. It produces the beat-0/beat-1 data and masks combinationally.
- The top level holds the FSM, the pending register, the timeout counter and the FIFO handshakes.

## Test plan
- 8 pixels at `0x10400000`..`0x1040001C`, FIFOs empty → exactly one AF push with `af_addr_din=0x10400000`, then two beats with mask `16'h0000` and data in slot order.
- Pixels at `0x10400004` and `0x10400008`, then a `flush` pulse → beat 0 mask `16'hF00F`, beat 1 mask `16'hFFFF`.
- A pixel at `0x10400000`, then one at `0x10400020` → the first burst drains, the second pixel is held in pending, then a `flush` drains the second burst with beat-0 mask `16'hFFF0`.
- `af_full=1` for 10 cycles during `DRAIN_AF`, then `wdf_full` pulsed during `W0` → no push while full, and exactly 1 AF push plus 2 WDF pushes total.
- 3 pixels merged, then `rst` pulled low for 1 cycle → no FIFO pushes, `idle=1`, and the next pixel starts a fresh burst.
- With `PWC_TIMEOUT_EN` and `TIMEOUT=4`: 1 pixel, then silence → AF push in the 5th cycle after the accept.
